// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped tagged 2-bit branch predictor (optional BP_BYPASS_EN forwarding)
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int LINES    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    output logic                br_pred_taken,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check,
    input  logic                clear
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    logic             valid_q [LINES];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [1:0]       ctr_q   [LINES];

    logic [IDX-1:0]   idx_g;
    logic [IDX-1:0]   idx_c;
    logic [TAG_W-1:0] tag_g;
    logic [TAG_W-1:0] tag_c;
    logic             hit_g;
    logic             hit_c;
    logic [1:0]       upd_ctr;

    // Byte-offset bits never participate in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc_guess[1:0], pc_check[1:0]};

    assign idx_g = pc_guess[IDX+1:2];
    assign tag_g = pc_guess[PC_WIDTH-1:IDX+2];
    assign idx_c = pc_check[IDX+1:2];
    assign tag_c = pc_check[PC_WIDTH-1:IDX+2];

    assign hit_g = valid_q[idx_g] && (tag_q[idx_g] == tag_g);
    assign hit_c = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    // New counter for the resolved branch: saturating step on a hit, weak allocation on a miss.
    always_comb begin
        upd_ctr = ctr_q[idx_c];
        if (hit_c) begin
            if (br_taken_check) begin
                if (ctr_q[idx_c] != 2'b11) upd_ctr = ctr_q[idx_c] + 2'b01;
            end else begin
                if (ctr_q[idx_c] != 2'b00) upd_ctr = ctr_q[idx_c] - 2'b01;
            end
        end else begin
            upd_ctr = br_taken_check ? 2'b10 : 2'b01;
        end
    end

    // Lookup; with forwarding enabled a same-cycle update to the same line and tag is seen immediately.
    always_comb begin
        br_pred_taken = is_br_guess && hit_g && ctr_q[idx_g][1];
`ifdef BP_BYPASS_EN
        if (rst_n && is_br_check && !clear && (idx_c == idx_g) && (tag_c == tag_g)) begin
            br_pred_taken = is_br_guess && upd_ctr[1];
        end
`endif
    end

    // Table state: reset/clear invalidate everything, otherwise only the indexed line is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (clear) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (is_br_check) begin
            valid_q[idx_c] <= 1'b1;
            tag_q[idx_c]   <= tag_c;
            ctr_q[idx_c]   <= upd_ctr;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        br_pred_taken;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;
    logic        clear;

    int n_checks;
    int n_fail;

`ifdef BP_BYPASS_EN
    localparam logic EXP_BYPASS = 1'b1;
`else
    localparam logic EXP_BYPASS = 1'b0;
`endif

    branch_predictor #(.PC_WIDTH(32), .LINES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_guess       (pc_guess),
        .is_br_guess    (is_br_guess),
        .br_pred_taken  (br_pred_taken),
        .pc_check       (pc_check),
        .is_br_check    (is_br_check),
        .br_taken_check (br_taken_check),
        .clear          (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a lookup between edges and let it settle.
    task automatic look(input logic [31:0] pc, input logic g);
        @(negedge clk);
        pc_guess    = pc;
        is_br_guess = g;
        #1;
    endtask

    // One qualified update across a single rising edge.
    task automatic upd(input logic [31:0] pc, input logic t);
        @(negedge clk);
        pc_check       = pc;
        br_taken_check = t;
        is_br_check    = 1'b1;
        @(posedge clk);
        #1;
        is_br_check    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; is_br_check = 1'b0; br_taken_check = 1'b0;
        pc_check = 32'h0; pc_guess = 32'h0000_1004; is_br_guess = 1'b1;
        #1;
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_pred: got %b want 0", br_pred_taken);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_pred: got %b want 0", br_pred_taken);
        end
    endtask

    task automatic test_counter;
        logic exp [6];
        logic t   [6];
        // alloc 10 ->1, 01 ->0, 00 ->0, 00 ->0 (sat), 01 ->0, 10 ->1
        t   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            upd(32'h0000_1004, t[i]);
            look(32'h0000_1004, 1'b1);
            n_checks++;
            if (br_pred_taken !== exp[i]) begin
                n_fail++; $display("FAIL counter_step%0d: got %b want %b", i, br_pred_taken, exp[i]);
            end
        end
    endtask

    task automatic test_saturate_high;
        // from 10: three taken -> 11, then not-taken -> 10
        repeat (3) upd(32'h0000_1004, 1'b1);
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL sat_high: got %b want 1", br_pred_taken);
        end
        upd(32'h0000_1004, 1'b0);
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL sat_high_dec: got %b want 1", br_pred_taken);
        end
        look(32'h0000_1004, 1'b0);
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL not_branch: got %b want 0", br_pred_taken);
        end
        // unqualified not-taken outcomes must leave counter 10 alone
        @(negedge clk);
        pc_check = 32'h0000_1004; br_taken_check = 1'b0; is_br_check = 1'b0;
        repeat (5) @(posedge clk);
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL idle_hold: got %b want 1", br_pred_taken);
        end
    endtask

    task automatic test_alias;
        repeat (2) upd(32'h0000_1004, 1'b1);   // 11
        upd(32'h0000_1008, 1'b1);              // index 2 -> 10
        upd(32'h0000_1024, 1'b0);              // evict index 1 -> tag 0x81, 01
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL alias_evicted: got %b want 0", br_pred_taken);
        end
        look(32'h0000_1024, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL alias_new: got %b want 0", br_pred_taken);
        end
        look(32'h0000_1008, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL alias_other_idx: got %b want 1", br_pred_taken);
        end
        upd(32'h0000_1024, 1'b1);              // hit: 01 -> 10
        look(32'h0000_1024, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL alias_hit_inc: got %b want 1", br_pred_taken);
        end
    endtask

    task automatic test_clear;
        logic [31:0] pcs [3];
        pcs = '{32'h0000_1008, 32'h0000_1024, 32'h0000_1004};
        @(negedge clk);
        clear = 1'b1;
        pc_check = 32'h0000_1008; br_taken_check = 1'b1; is_br_check = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; is_br_check = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look(pcs[i], 1'b1);
            n_checks++;
            if (br_pred_taken !== 1'b0) begin
                n_fail++; $display("FAIL clear_pc%0d: got %b want 0", i, br_pred_taken);
            end
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        pc_guess = 32'h0000_1004; is_br_guess = 1'b1;
        pc_check = 32'h0000_1004; br_taken_check = 1'b1; is_br_check = 1'b1;
        #1;
        n_checks++;
        if (br_pred_taken !== EXP_BYPASS) begin
            n_fail++; $display("FAIL same_cycle: got %b want %b", br_pred_taken, EXP_BYPASS);
        end
        @(posedge clk);
        #1;
        is_br_check = 1'b0;
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL after_same_cycle: got %b want 1", br_pred_taken);
        end
    endtask

    task automatic test_reset_mid;
        // 0x1004 holds 10; a taken update is pending when reset hits
        @(negedge clk);
        pc_check = 32'h0000_1004; br_taken_check = 1'b1; is_br_check = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_async: got %b want 0", br_pred_taken);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; is_br_check = 1'b0;
        look(32'h0000_1004, 1'b1);
        n_checks++;
        if (br_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_drop: got %b want 0", br_pred_taken);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_counter();
        test_saturate_high();
        test_alias();
        test_clear();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor directly upstream of the stage-1 control logic; produces the taken/not-taken guess that drives branch-label selection.
- Direct-mapped table of tagged 2-bit saturating counters.
- Looked up combinationally with the stage-1 PC; updated one edge after the stage-3 branch outcome is presented.

Parameters:
- PC_WIDTH, 32, program counter width in bits.
- LINES, 8, number of table entries; must be a power of two, >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_guess  input  PC_WIDTH  PC of the instruction in stage 1.
- is_br_guess  input  1  stage-1 instruction is a conditional branch.
- br_pred_taken  output  1  prediction for the stage-1 branch.
- pc_check  input  PC_WIDTH  PC of the resolved branch in stage 3.
- is_br_check  input  1  stage-3 instruction is a conditional branch; qualifies the update.
- br_taken_check  input  1  actual outcome of the stage-3 branch.
- clear  input  1  synchronous invalidate of the whole table.

Behaviour:
- IDX = log2(LINES).
- index = pc[IDX+1:2].
- tag = pc[PC_WIDTH-1:IDX+2]; pc[1:0] ignored.
- Entry state: valid (1 bit), tag, counter (2 bits).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - hit = valid[idx_g] && tag[idx_g] == tag_g.
  - br_pred_taken = is_br_guess && hit && counter[idx_g][1].
  - Otherwise 0.
- Update (registered; visible to lookup on the cycle after the edge), only when is_br_check=1:
  - Hit, taken: counter increments, saturating at 11.
  - Hit, not taken: counter decrements, saturating at 00.
  - Miss (invalid entry or tag mismatch): allocate by overwriting the entry. Set valid=1, tag=tag_c. Counter = 10 if taken, 01 if not.
  - is_br_check=0: no state change.
- Only the indexed entry changes on an update; all others hold.
- Reset (rst_n low, asynchronous):
  - All valid=0, counters=01, tags=0.
  - br_pred_taken therefore reads 0 immediately after reset.
  - Reset asserted mid-update discards that update.
- clear=1 at an edge:
  - Sets all valid=0 and counters=01.
  - Takes priority over a simultaneous update, which is dropped.
- Same index looked up and updated in the same cycle: lookup returns pre-update state (no forwarding) unless BP_BYPASS_EN.
- Aliasing: PCs sharing index but differing in tag miss and evict each other; there is no associativity.

Optional Feature:
- Macro: BP_BYPASS_EN.
- Defined: when is_br_check=1 and the index and tag of pc_check equal those of pc_guess in the same cycle, the lookup forwards the post-update entry.
  - br_pred_taken reflects the new counter's MSB, or the allocated value on a miss.
  - clear=1 suppresses the bypass.
- Undefined: lookup always reads registered state; the update is seen one cycle later.
- Table state after the edge is identical in both builds.

Test Plan (LINES=8, PC_WIDTH=32; PC 0x00001004 -> index 1, tag 0x80):
- Reset, then is_br_guess=1, pc_guess=0x00001004 -> br_pred_taken=0. Same result during rst_n low mid-run.
- One update, taken, at 0x00001004 -> next cycle lookup = 1 (counter 10). Two not-taken updates -> counter 00, lookup 0. Third not-taken stays 00 (saturation). Then one taken -> 01, lookup still 0.
- Three taken updates at 0x00001004 -> 11, lookup 1. Then is_br_guess=0 with the same PC -> br_pred_taken=0. Then is_br_check=0 for 5 cycles -> counter unchanged.
- Alias: train 0x00001004 to 11, then one not-taken update at 0x00001024 (same index 1, tag 0x81) -> lookup 0x00001004 = 0 (miss) and lookup 0x00001024 = 0 (counter 01). Index 2 entries untouched.
- clear=1 with a simultaneous taken update at 0x00001008 -> next cycle all lookups 0, including 0x00001008.
- Same-cycle lookup and update, taken, on an untrained 0x00001004 -> br_pred_taken=0 without BP_BYPASS_EN, 1 with it. The following cycle reads 1 in both builds.
